// File: rtl/pipe_output_buffer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pipe_output_buffer_fifo
// Brief    : Circular storage and pointers for the pipe output buffer.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_output_buffer_fifo #(
    parameter int width = 8,
    parameter int depth = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [width-1:0]             din,
    output logic [width-1:0]             dout,
    output logic [$clog2(depth+1)-1:0]   count
);
    localparam int PW = $clog2(depth);
    localparam int CW = $clog2(depth+1);
    localparam logic [PW-1:0] c_last = PW'(depth - 1);

    logic [width-1:0] r_mem [depth];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + PW'(1);
            end
            if (pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                r_count <= r_count + CW'(1);
            end else if (pop && !push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
endmodule
`default_nettype wire

// File: rtl/pipe_output_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pipe_output_buffer
// Brief    : Credit-controlled output buffer behind a fixed-latency pipe.
//            Optional same-cycle bypass: PIPE_OUTPUT_BUFFER_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_output_buffer #(
    parameter int width = 8,
    parameter int depth = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_vld,
    output logic             issue_rdy,
    input  logic             pipe_vld,
    input  logic [width-1:0] pipe_data,
    output logic             out_vld,
    output logic [width-1:0] out_data,
    input  logic             out_rdy,
    output logic             overflow_err
);
    localparam int CW = $clog2(depth+1);
    localparam logic [CW-1:0] c_depth = CW'(depth);

    logic [CW-1:0]    r_credit;
    logic             r_overflow;
    logic [CW-1:0]    w_occ;
    logic [width-1:0] w_head;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_fifo_push;
    logic             w_fifo_pop;
    logic             w_issue_fire;

    assign w_empty = (w_occ == '0);
    assign w_full  = (w_occ == c_depth);

`ifdef PIPE_OUTPUT_BUFFER_BYPASS_EN
    logic w_bypass;
    // Bypass is gated by rst so out_vld stays low throughout reset.
    assign w_bypass    = w_empty & pipe_vld & ~rst;
    assign out_vld     = ~w_empty | w_bypass;
    assign out_data    = w_bypass ? pipe_data : w_head;
    assign w_pop       = out_vld & out_rdy;
    assign w_fifo_pop  = w_pop & ~w_empty;
    assign w_fifo_push = pipe_vld & ~(w_bypass & out_rdy) & (~w_full | w_fifo_pop);
`else
    assign out_vld     = ~w_empty;
    assign out_data    = w_head;
    assign w_pop       = out_vld & out_rdy;
    assign w_fifo_pop  = w_pop;
    assign w_fifo_push = pipe_vld & (~w_full | w_fifo_pop);
`endif

    assign issue_rdy    = (r_credit < c_depth);
    assign w_issue_fire = issue_vld & issue_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credit   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_issue_fire && !w_pop) begin
                r_credit <= r_credit + CW'(1);
            end else if (!w_issue_fire && w_pop && (r_credit != '0)) begin
                r_credit <= r_credit - CW'(1);
            end
            if (pipe_vld && w_full && !w_fifo_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign overflow_err = r_overflow;

    pipe_output_buffer_fifo #(
        .width (width),
        .depth (depth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_fifo_push),
        .pop   (w_fifo_pop),
        .din   (pipe_data),
        .dout  (w_head),
        .count (w_occ)
    );
endmodule
`default_nettype wire

// File: tb/tb_pipe_output_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_output_buffer
// Brief    : Directed bench with a queue-based reference model (depth=4, width=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_output_buffer;
    localparam int W = 8;
    localparam int D = 4;
`ifdef PIPE_OUTPUT_BUFFER_BYPASS_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         issue_vld = 1'b0;
    logic         issue_rdy;
    logic         pipe_vld = 1'b0;
    logic [W-1:0] pipe_data = '0;
    logic         out_vld;
    logic [W-1:0] out_data;
    logic         out_rdy = 1'b0;
    logic         overflow_err;

    int checks = 0;
    int failures = 0;

    pipe_output_buffer #(.width(W), .depth(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_vld    (issue_vld),
        .issue_rdy    (issue_rdy),
        .pipe_vld     (pipe_vld),
        .pipe_data    (pipe_data),
        .out_vld      (out_vld),
        .out_data     (out_data),
        .out_rdy      (out_rdy),
        .overflow_err (overflow_err)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a queue of stored entries, a credit integer, a sticky flag.
    logic [W-1:0] mq[$];
    int           mcred = 0;
    bit           movf = 1'b0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                mcred = 0;
                movf  = 1'b0;
            end else begin
                bit bp, vld, pop, fire;
                bp   = BP && (mq.size() == 0) && pipe_vld;
                vld  = (mq.size() != 0) || bp;
                pop  = vld && out_rdy;
                fire = issue_vld && (mcred < D);
                if (bp) begin
                    if (!out_rdy) mq.push_back(pipe_data);
                end else begin
                    if (pop) void'(mq.pop_front());
                    if (pipe_vld) begin
                        if (mq.size() < D) mq.push_back(pipe_data);
                        else movf = 1'b1;
                    end
                end
                if (fire && !pop) mcred++;
                else if (!fire && pop && mcred > 0) mcred--;
            end
        end
    end

    logic         exp_vld;
    logic [W-1:0] exp_data;
    always @(negedge clk) begin
        exp_vld  = !rst && ((mq.size() != 0) || (BP && pipe_vld));
        exp_data = (mq.size() != 0) ? mq[0] : pipe_data;
        chk("cyc_out_vld", {31'd0, out_vld}, {31'd0, exp_vld});
        chk("cyc_issue_rdy", {31'd0, issue_rdy}, {31'd0, (mcred < D)});
        chk("cyc_overflow_err", {31'd0, overflow_err}, {31'd0, movf});
        if (exp_vld) chk("cyc_out_data", {24'd0, out_data}, {24'd0, exp_data});
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    logic [W-1:0] got[$];
    logic [W-1:0] v30[3];
    int fires;

    initial begin
        v30[0] = 8'h11; v30[1] = 8'h22; v30[2] = 8'h33;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_vld", {31'd0, out_vld}, 32'd0);
        chk("reset_issue_rdy", {31'd0, issue_rdy}, 32'd1);
        chk("reset_overflow", {31'd0, overflow_err}, 32'd0);
        step();
        rst = 1'b0;

        // Credit exhaustion with no pops.
        issue_vld = 1'b1;
        fires = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (issue_rdy) fires++;
            if (i == 4) chk("issue_rdy_5th", {31'd0, issue_rdy}, 32'd0);
            step();
        end
        issue_vld = 1'b0;
        chk("issue_fires", fires, 32'd4);

        // Streaming latency.
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pipe_vld  = (i < 3);
            pipe_data = (i < 3) ? v30[i] : 8'h00;
            @(negedge clk);
`ifdef PIPE_OUTPUT_BUFFER_BYPASS_EN
            if (i < 3) chk("stream_data", {24'd0, out_data}, {24'd0, v30[i]});
`else
            if (i >= 1) chk("stream_data", {24'd0, out_data}, {24'd0, v30[i-1]});
`endif
            step();
        end
        pipe_vld = 1'b0;

        // Fill, then simultaneous push and pop while full.
        out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pipe_vld  = 1'b1;
            pipe_data = 8'hA0 + 8'(i);
            step();
        end
        pipe_data = 8'hA4;
        out_rdy   = 1'b1;
        step();
        pipe_vld = 1'b0;
        out_rdy  = 1'b0;
        @(negedge clk);
        chk("full_pushpop_ovf", {31'd0, overflow_err}, 32'd0);
        chk("full_pushpop_head", {24'd0, out_data}, 32'hA1);
        step();

        // Overflow while full and stalled.
        pipe_vld  = 1'b1;
        pipe_data = 8'h55;
        step();
        pipe_vld = 1'b0;
        @(negedge clk);
        chk("overflow_set", {31'd0, overflow_err}, 32'd1);
        step();
        out_rdy = 1'b1;
        got.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_vld) got.push_back(out_data);
            step();
        end
        out_rdy = 1'b0;
        chk("drain_count", got.size(), 32'd4);
        for (int i = 0; i < 4; i++) chk("drain_order", {24'd0, got[i]}, 32'hA1 + i);
        chk("overflow_sticky", {31'd0, overflow_err}, 32'd1);

        // Wrap-around streaming of 0x00..0x07.
        got.delete();
        out_rdy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            pipe_vld  = (i < 8);
            pipe_data = 8'(i);
            @(negedge clk);
            if (out_vld) got.push_back(out_data);
            step();
        end
        pipe_vld = 1'b0;
        out_rdy  = 1'b0;
        chk("wrap_count", got.size(), 32'd8);
        for (int i = 0; i < 8; i++) chk("wrap_order", {24'd0, got[i]}, i);

        // Asynchronous reset with 3 entries held and credits exhausted.
        issue_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pipe_vld  = 1'b1;
            pipe_data = 8'hC0 + 8'(i);
            step();
        end
        pipe_vld = 1'b0;
        step();
        issue_vld = 1'b0;
        @(negedge clk);
        chk("pre_rst_issue_rdy", {31'd0, issue_rdy}, 32'd0);
        chk("pre_rst_out_data", {24'd0, out_data}, 32'hC0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_vld", {31'd0, out_vld}, 32'd0);
        chk("async_rst_issue_rdy", {31'd0, issue_rdy}, 32'd1);
        chk("async_rst_overflow", {31'd0, overflow_err}, 32'd0);
        #3 rst = 1'b0;
        pipe_vld  = 1'b1;
        pipe_data = 8'h99;
        step();
        pipe_vld = 1'b0;
        @(negedge clk);
        chk("post_rst_first", {24'd0, out_data}, 32'h99);
        chk("post_rst_vld", {31'd0, out_vld}, 32'd1);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pipe_output_buffer.md
PIPE_OUTPUT_BUFFER -- requirements
Module: pipe_output_buffer

Interface
REQ-001 Parameter width, default 8: data bits per transfer.
REQ-002 Parameter depth, default 8: buffer entries; credits available to upstream issuer.
REQ-003 clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 issue_vld  input  1  issuer requests to launch one transfer into the fixed-latency pipe.
REQ-006 issue_rdy  output  1  credit available; issue fires when issue_vld & issue_rdy.
REQ-007 pipe_vld  input  1  valid from pipe output; no backpressure possible.
REQ-008 pipe_data  input  width  data from pipe output, sampled only when pipe_vld.
REQ-009 out_vld  output  1  buffered transfer available downstream.
REQ-010 out_data  output  width  head-of-buffer data, meaningful only when out_vld.
REQ-011 out_rdy  input  1  downstream accepts; pop when out_vld & out_rdy.
REQ-012 overflow_err  output  1  sticky: pipe_vld arrived while buffer full.

Function
REQ-013 Credit counter (0..depth) shall count issued-but-not-popped transfers: +1 on issue fire, -1 on pop, unchanged if both or neither in the same cycle.
REQ-014 issue_rdy shall be combinational (credit counter < depth), independent of issue_vld.
REQ-015 Buffer shall be a circular FIFO of depth entries; write pointer advances on pipe_vld, read pointer on pop, both wrap from depth-1 to 0.
REQ-016 Occupancy counter (0..depth) shall track stored entries; simultaneous push and pop leave it unchanged and are both performed, including when full.
REQ-017 out_vld shall equal (occupancy != 0) in the non-bypass build; out_data shall be the entry at the read pointer.
REQ-018 pipe_vld when occupancy == depth and no pop that cycle: data dropped, pointers unchanged, overflow_err set and held until reset.
REQ-019 Pop with out_vld low shall have no effect; credit counter shall never underflow or exceed depth.
REQ-020 Latency (non-bypass): pipe_vld at cycle N -> out_vld at N+1 if buffer was empty.
REQ-021 Ordering: transfers leave in arrival order, no duplication, no loss except per REQ-018.

Reset
REQ-022 While rst high: pointers, occupancy, credit counter = 0; out_vld = 0; overflow_err = 0; issue_rdy = 1.
REQ-023 Reset mid-operation discards all in-flight credits and buffered entries; storage array is not reset.
REQ-024 First pipe_vld honoured on the first posedge after rst deasserts.

Configuration
REQ-025 Macro PIPE_OUTPUT_BUFFER_BYPASS_EN: when defined, with buffer empty and pipe_vld high, out_vld = 1 and out_data = pipe_data in the same cycle; if out_rdy also high the transfer is not written and counts as a pop.
REQ-026 Without the macro, no combinational path from pipe_vld/pipe_data to out_vld/out_data; latency per REQ-020.

Structure
REQ-027 No shared package; counter widths derived locally as $clog2(depth+1), pointer width $clog2(depth).
REQ-028 Storage and pointers in one sub-module pipe_output_buffer_fifo; credit logic and overflow flag in the top.

Verification (depth=4, width=8)
REQ-029 Reset, then issue_vld=1 for 6 cycles, out_rdy=0 -> exactly 4 issues fire, issue_rdy=0 from the 5th cycle.
REQ-030 pipe_vld with data 0x11,0x22,0x33 on consecutive cycles, out_rdy=1 -> out_data 0x11,0x22,0x33 one cycle later each (non-bypass), same cycle with PIPE_OUTPUT_BUFFER_BYPASS_EN.
REQ-031 Buffer full (4 entries), pipe_vld=1 and out_rdy=1 same cycle -> occupancy stays 4, head popped, new entry stored, overflow_err=0.
REQ-032 Buffer full, pipe_vld=1 data 0x55, out_rdy=0 -> overflow_err=1 and stays 1; 0x55 never appears on out_data.
REQ-033 8 pushes/pops with values 0x00..0x07 -> pointers wrap, output order 0x00..0x07 intact.
REQ-034 rst asserted asynchronously between clock edges with 3 entries held -> out_vld=0 and issue_rdy=1 immediately, before next posedge.
